deshifter: RTL and testbench

- Serial-in/parallel-out receiver: collects a W-bit word, one bit per clk while WORK=1, LSB first.
- Presents each completed word on a valid/ready output with overflow detection.
- Sits on the receive side of the crossbar arbiter's serial priority/grant links and reassembles 4-bit vectors emitted one bit per cycle by the rotating shift registers.
- Output words feed the arbiter control logic.

---
 rtl/deshifter_pkg.sv | 42 ++++
 rtl/deshifter_cnt.sv | 45 ++++
 rtl/deshifter.sv | 114 +++++++++++
 tb/tb_deshifter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deshifter_pkg.sv
// deshifter_pkg
//   Shared constants and helpers for the serial receive path of the
//   crossbar arbiter (deshifter and its bit counter). The transmit side
//   can reuse the same frame length and counter width helpers.
//
//   Build option: DESHIFTER_PARITY_EN
//     undefined -> a frame is W data bits
//     defined   -> a frame is W data bits followed by one even-parity bit
//
//   Contents:
//     DESHIFT_W_DEFAULT  default word width
//     DESHIFT_PAR_BITS   number of parity bits appended to a frame (0 or 1)
//     DESHIFT_FRAME_LEN  frame length for the default word width
//     frame_len(w)       frame length for word width w
//     cnt_width(n)       bits needed to count 0..n-1 (minimum 1)
package deshifter_pkg;

  localparam int DESHIFT_W_DEFAULT = 4;

`ifdef DESHIFTER_PARITY_EN
  localparam int DESHIFT_PAR_BITS = 1;
`else
  localparam int DESHIFT_PAR_BITS = 0;
`endif

  localparam int DESHIFT_FRAME_LEN = DESHIFT_W_DEFAULT + DESHIFT_PAR_BITS;

  function automatic int frame_len(input int w);
    return w + DESHIFT_PAR_BITS;
  endfunction

  // Ceiling log2, but never below 1 so a counter always has at least one bit.
  function automatic int cnt_width(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/deshifter_cnt.sv
// deshifter_cnt
//   Wrapping bit counter for serial framing. Counts 0..N-1 while en=1 and
//   wraps to 0 after N-1. A synchronous clear restarts the frame; if en is
//   also high in that cycle the bit being sampled counts as bit 0 of the new
//   frame, so the counter loads 1.
//
//   Parameters:
//     N   frame length (number of counts before wrap)
//     CW  counter width
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     en     count enable (one bit sampled this cycle)
//     clr    frame restart
//     cnt    current count
//     tc     terminal count: cnt == N-1 (combinational from cnt)
module deshifter_cnt
  import deshifter_pkg::*;
#(
  parameter int N  = DESHIFT_FRAME_LEN,
  parameter int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      // A restart that coincides with a sampled bit makes that bit bit 0.
      cnt <= en ? CW'(1) : '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/deshifter.sv
// deshifter
//   Serial-in/parallel-out receiver. Reassembles W-bit words sent LSB first,
//   one bit per clk while WORK=1, and presents each completed word on a
//   valid/ready slot. A word completing while the slot is still occupied is
//   dropped and flagged on the sticky overflow output.
//
//   Build option: DESHIFTER_PARITY_EN
//     When defined, each frame carries an extra even-parity bit after the
//     data bits, and par_err reports a parity mismatch for the word in the
//     output slot. The word is delivered regardless of parity.
//
//   Ports:
//     clk         rising-edge clock
//     reset       asynchronous, active-low reset
//     in          serial data bit, sampled when WORK=1
//     WORK        shift enable; 0 freezes the deserialiser
//     sync        frame restart; discards the partial word
//     data        last completed word
//     data_valid  data holds an unconsumed word
//     data_ready  consumer accepts data while data_valid=1
//     overflow    sticky; a completed word was dropped
//     ovf_clr     clears overflow (a same-cycle drop wins)
//     bit_cnt     bits collected of the current frame
//     par_err     (parity build only) parity mismatch on data
module deshifter
  import deshifter_pkg::*;
#(
  parameter  int W     = DESHIFT_W_DEFAULT,
  localparam int F     = frame_len(W),
  localparam int CNT_W = cnt_width(F)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             WORK,
  input  logic             sync,
  output logic [W-1:0]     data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] bit_cnt
`ifdef DESHIFTER_PARITY_EN
  ,
  output logic             par_err
`endif
);

  // Only the first F-1 bits of a frame need storing; the last bit is taken
  // straight from `in` when the frame completes.
  logic [F-2:0] shreg;
  logic [F-1:0] cand;
  logic         cnt_tc;
  logic         complete;
  logic         slot_free;

  assign cand      = {in, shreg};
  assign complete  = WORK && cnt_tc && !sync;
  assign slot_free = !data_valid || data_ready;

  deshifter_cnt #(
    .N  (F),
    .CW (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (WORK),
    .clr   (sync),
    .cnt   (bit_cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if (sync) begin
      // New frame: a bit sampled with sync enters at the top and will have
      // shifted down to position 0 by the time the frame completes.
      shreg <= '0;
      if (WORK) shreg[F-2] <= in;
    end else if (WORK) begin
      shreg <= cand[F-1:1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data       <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
`ifdef DESHIFTER_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      if (ovf_clr) overflow <= 1'b0;

      if (complete) begin
        if (slot_free) begin
          data       <= cand[W-1:0];
          data_valid <= 1'b1;
`ifdef DESHIFTER_PARITY_EN
          // Even parity over data plus parity bit must be zero.
          par_err    <= ^cand;
`endif
        end else begin
          overflow <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deshifter.sv
// tb_deshifter
//   Directed bench for deshifter. Expected words are queued when a frame is
//   sent and compared by a monitor when the DUT presents a new word; other
//   status outputs are checked at fixed points in the sequence.
module tb_deshifter;
  import deshifter_pkg::*;

  localparam int W     = DESHIFT_W_DEFAULT;
  localparam int F     = frame_len(W);
  localparam int CNT_W = cnt_width(F);

  logic             clk = 1'b0;
  logic             reset;
  logic             in;
  logic             WORK;
  logic             sync;
  logic [W-1:0]     data;
  logic             data_valid;
  logic             data_ready;
  logic             overflow;
  logic             ovf_clr;
  logic [CNT_W-1:0] bit_cnt;
`ifdef DESHIFTER_PARITY_EN
  logic             par_err;
`endif

  typedef struct packed {
    logic         perr;
    logic [W-1:0] word;
  } exp_t;

  exp_t expq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic seen        = 1'b0;

  deshifter #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .WORK       (WORK),
    .sync       (sync),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .bit_cnt    (bit_cnt)
`ifdef DESHIFTER_PARITY_EN
    ,
    .par_err    (par_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of serial input, then return 1 time unit after the edge.
  task automatic applyStimulus(input logic b_in, input logic b_work, input logic b_sync);
    in   = b_in;
    WORK = b_work;
    sync = b_sync;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendBits(input logic [F-1:0] frame, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(frame[i], 1'b1, 1'b0);
  endtask

  function automatic logic [F-1:0] mkFrame(input logic [W-1:0] w);
`ifdef DESHIFTER_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  function automatic exp_t mkExp(input logic [W-1:0] w, input logic pe);
    exp_t e;
    e.word = w;
    e.perr = pe;
    return e;
  endfunction

  // Scoreboard: compare once per newly presented word.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      seen = 1'b0;
    end else if (data_valid) begin
      if (!seen) begin
        seen = 1'b1;
        vectors++;
        assert (expq.size() != 0) else begin
          miscompares++;
          $error("[TB] FAIL unexpected_word: observed %0h expected none", data);
        end
        if (expq.size() != 0) begin
          e = expq.pop_front();
          checkOutput("sb_data", 32'(data), 32'(e.word));
`ifdef DESHIFTER_PARITY_EN
          checkOutput("sb_par_err", 32'(par_err), 32'(e.perr));
`endif
        end
      end
      if (data_ready) seen = 1'b0;
    end
  end

  initial begin
    logic [F-1:0] fr;
    logic [W-1:0] b2b [3];
    b2b[0] = 4'h3;
    b2b[1] = 4'hA;
    b2b[2] = 4'hF;

    reset = 1'b0; in = 1'b0; WORK = 1'b0; sync = 1'b0;
    data_ready = 1'b0; ovf_clr = 1'b0;

    #3;
    checkOutput("reset_data", 32'(data), 32'h0);
    checkOutput("reset_valid", 32'(data_valid), 32'h0);
    checkOutput("reset_overflow", 32'(overflow), 32'h0);
    checkOutput("reset_bit_cnt", 32'(bit_cnt), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    idle();

    $display("[TB] basic word");
    data_ready = 1'b1;
    expq.push_back(mkExp(4'hD, 1'b0));
    sendBits(mkFrame(4'hD), 0, F - 1);
    checkOutput("basic_valid_rise", 32'(data_valid), 32'h1);
    checkOutput("basic_bit_cnt_wrap", 32'(bit_cnt), 32'h0);
    idle();
    checkOutput("basic_valid_pulse", 32'(data_valid), 32'h0);

    $display("[TB] back-to-back words");
    for (int k = 0; k < 3; k++) begin
      expq.push_back(mkExp(b2b[k], 1'b0));
      sendBits(mkFrame(b2b[k]), 0, F - 1);
      checkOutput("b2b_valid", 32'(data_valid), 32'h1);
    end
    idle();
    checkOutput("b2b_valid_drop", 32'(data_valid), 32'h0);
    checkOutput("b2b_overflow", 32'(overflow), 32'h0);

    $display("[TB] backpressure");
    data_ready = 1'b0;
    expq.push_back(mkExp(4'h5, 1'b0));
    sendBits(mkFrame(4'h5), 0, F - 1);
    checkOutput("bp_no_overflow_yet", 32'(overflow), 32'h0);
    sendBits(mkFrame(4'h9), 0, F - 1);
    checkOutput("bp_data_hold", 32'(data), 32'h5);
    checkOutput("bp_overflow", 32'(overflow), 32'h1);
    checkOutput("bp_valid_hold", 32'(data_valid), 32'h1);
    idle();
    idle();
    checkOutput("bp_overflow_sticky", 32'(overflow), 32'h1);
    ovf_clr = 1'b1;
    idle();
    ovf_clr = 1'b0;
    checkOutput("bp_overflow_clr", 32'(overflow), 32'h0);
    checkOutput("bp_valid_after_clr", 32'(data_valid), 32'h1);
    data_ready = 1'b1;
    idle();
    checkOutput("bp_valid_drop", 32'(data_valid), 32'h0);
    checkOutput("bp_data_after_drop", 32'(data), 32'h5);

    $display("[TB] WORK gap");
    fr = mkFrame(4'h6);
    expq.push_back(mkExp(4'h6, 1'b0));
    sendBits(fr, 0, 1);
    repeat (5) idle();
    checkOutput("gap_bit_cnt_hold", 32'(bit_cnt), 32'h2);
    sendBits(fr, 2, F - 1);
    idle();

    $display("[TB] sync restart");
    sendBits(mkFrame(4'hE), 0, 2);
    checkOutput("sync_pre_bit_cnt", 32'(bit_cnt), 32'h3);
    fr = mkFrame(4'hB);
    expq.push_back(mkExp(4'hB, 1'b0));
    applyStimulus(fr[0], 1'b1, 1'b1);
    checkOutput("sync_bit_cnt", 32'(bit_cnt), 32'h1);
    checkOutput("sync_no_word", 32'(data_valid), 32'h0);
    sendBits(fr, 1, F - 1);
    checkOutput("sync_valid", 32'(data_valid), 32'h1);
    idle();

    $display("[TB] reset mid-word");
    sendBits(mkFrame(4'h9), 0, 1);
    WORK = 1'b0;
    in = 1'b0;
    reset = 1'b0;
    #2;
    checkOutput("midrst_bit_cnt", 32'(bit_cnt), 32'h0);
    checkOutput("midrst_data", 32'(data), 32'h0);
    checkOutput("midrst_valid", 32'(data_valid), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    idle();
    checkOutput("midrst_no_spurious", 32'(data_valid), 32'h0);
    expq.push_back(mkExp(4'h6, 1'b0));
    sendBits(mkFrame(4'h6), 0, F - 1);
    checkOutput("midrst_valid_rise", 32'(data_valid), 32'h1);
    checkOutput("midrst_data_word", 32'(data), 32'h6);
    idle();

`ifdef DESHIFTER_PARITY_EN
    $display("[TB] parity");
    expq.push_back(mkExp(4'h7, 1'b0));
    sendBits({1'b1, 4'h7}, 0, F - 1);
    checkOutput("par_good", 32'(par_err), 32'h0);
    idle();
    expq.push_back(mkExp(4'h7, 1'b1));
    sendBits({1'b0, 4'h7}, 0, F - 1);
    checkOutput("par_bad", 32'(par_err), 32'h1);
    checkOutput("par_bad_data", 32'(data), 32'h7);
    idle();
`endif

    idle();
    idle();
    checkOutput("queue_empty", 32'(expq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
